// File: rtl/laplace_window_if.sv
// Pixel-in / window-out bundle of the Laplace window generator.
// The slave side is the generator; the master side feeds pixels and consumes windows.
interface laplace_window_if #(
  parameter int DW = 8,
  parameter int CW = 9
);
  logic [DW-1:0] pix_in;
  logic          pix_valid;
  logic          sof;
  logic [DW-1:0] b;
  logic [DW-1:0] d;
  logic [DW-1:0] e;
  logic [DW-1:0] f;
  logic [DW-1:0] h;
  logic          win_valid;
  logic [CW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic          frame_done;

  modport master (
    output pix_in, pix_valid, sof,
    input  b, d, e, f, h, win_valid, win_row, win_col, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output b, d, e, f, h, win_valid, win_row, win_col, frame_done
  );
endinterface

// File: rtl/laplace_window_gen.sv
// Raster-order pixel stream to 5-point cross window (b,d,e,f,h) generator
// with two line buffers; one registered window per interior pixel.
//
// state  | meaning
// IDLE   | waiting for sof, non-sof pixels dropped
// FILL   | rows 0-1 / first columns of a frame, storing only
// STREAM | row >= 2 reached, windows produced for columns >= 2
module laplace_window_gen #(
  parameter int COLS = 512,
  parameter int ROWS = 512,
  parameter int DW   = 8,
  parameter int CW   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  laplace_window_if.slave  win
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  localparam int            AW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_R = CW'(ROWS - 1);
  localparam logic [CW-1:0] TWO    = CW'(2);

  state_t        state_q, state_d;
  logic [CW-1:0] r_q, c_q, r_d, c_d;
  logic [CW-1:0] pos_r, pos_c;
  logic          accept, win_fire, last_fire;

  logic [DW-1:0] lb1 [COLS];
  logic [DW-1:0] lb2 [COLS];
  logic [DW-1:0] lb1_rd, lb2_rd;
  logic [DW-1:0] t1_1, t1_2, t2_1, cur_1;
  logic [AW-1:0] addr;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    pos_r     = r_q;
    pos_c     = c_q;
    accept    = 1'b0;
    win_fire  = 1'b0;
    last_fire = 1'b0;
    if (win.pix_valid) begin
      // sof restarts the frame from any state, aborting silently
      if (win.sof) begin
        pos_r   = '0;
        pos_c   = '0;
        accept  = 1'b1;
        state_d = FILL;
      end else if (state_q != IDLE) begin
        accept    = 1'b1;
        win_fire  = (r_q >= TWO) && (c_q >= TWO);
        last_fire = (r_q == LAST_R) && (c_q == LAST_C);
        if (last_fire)
          state_d = IDLE;
        else if (win_fire)
          state_d = STREAM;
      end
      if (accept) begin
        if (last_fire) begin
          r_d = '0;
          c_d = '0;
        end else if (pos_c == LAST_C) begin
          r_d = pos_r + 1'b1;
          c_d = '0;
        end else begin
          r_d = pos_r;
          c_d = pos_c + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
    end
  end

  assign addr   = pos_c[AW-1:0];
  assign lb1_rd = lb1[addr];
  assign lb2_rd = lb2[addr];

  // lb1 holds row r-1, lb2 row r-2; the row moves down one buffer as it is overwritten
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[addr] <= win.pix_in;
      lb2[addr] <= lb1_rd;
      t1_2      <= t1_1;
      t1_1      <= lb1_rd;
      t2_1      <= lb2_rd;
      cur_1     <= win.pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win.b          <= '0;
      win.d          <= '0;
      win.e          <= '0;
      win.f          <= '0;
      win.h          <= '0;
      win.win_row    <= '0;
      win.win_col    <= '0;
      win.win_valid  <= 1'b0;
      win.frame_done <= 1'b0;
    end else begin
      win.win_valid  <= win_fire;
      win.frame_done <= last_fire;
      if (win_fire) begin
        win.b       <= t2_1;
        win.d       <= t1_2;
        win.e       <= t1_1;
        win.f       <= lb1_rd;
        win.h       <= cur_1;
        win.win_row <= r_q - TWO;
        win.win_col <= c_q - TWO;
      end
    end
  end

endmodule

// File: tb/tb_laplace_window_gen.sv
// Randomized bench for laplace_window_gen on an 8x8 frame: a pixel-array model
// predicts every window and the cycle it must appear on.
module tb_laplace_window_gen;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 8;
  localparam int CW   = 4;

  typedef struct {
    logic [DW-1:0] b, d, e, f, h;
    int            row, col;
    bit            done;
    int            due;
  } win_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  laplace_window_if #(.DW(DW), .CW(CW)) wif ();

  laplace_window_gen #(.COLS(COLS), .ROWS(ROWS), .DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .win   (wif)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  win_t          expq[$];
  logic [DW-1:0] src   [ROWS][COLS];
  logic [DW-1:0] m_img [ROWS][COLS];
  bit            m_active = 1'b0;
  int            m_r = 0, m_c = 0;

  int            n_win = 0, n_done = 0;
  logic [DW-1:0] first_b, first_d, first_e, first_f, first_h;
  logic [DW-1:0] last_b, last_d, last_e, last_f, last_h;
  int            last_row, last_col;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // frame semantics at pixel level: position tracking, abort on sof, window from the stored image
  task automatic model_accept(input logic [DW-1:0] pix, input bit s);
    win_t w;
    if (s) begin
      m_active = 1'b1;
      m_r = 0;
      m_c = 0;
    end else if (!m_active) begin
      return;
    end
    m_img[m_r][m_c] = pix;
    if (!s && m_r >= 2 && m_c >= 2) begin
      w.b    = m_img[m_r-2][m_c-1];
      w.d    = m_img[m_r-1][m_c-2];
      w.e    = m_img[m_r-1][m_c-1];
      w.f    = m_img[m_r-1][m_c];
      w.h    = m_img[m_r][m_c-1];
      w.row  = m_r - 2;
      w.col  = m_c - 2;
      w.done = (m_r == ROWS-1) && (m_c == COLS-1);
      w.due  = cyc + 1;
      expq.push_back(w);
    end
    if (m_r == ROWS-1 && m_c == COLS-1) begin
      m_active = 1'b0;
      m_r = 0;
      m_c = 0;
    end else if (m_c == COLS-1) begin
      m_c = 0;
      m_r++;
    end else begin
      m_c++;
    end
  endtask

  task automatic drive(input logic [DW-1:0] pix, input bit v, input bit s);
    @(posedge clk);
    #1;
    wif.pix_in    = pix;
    wif.pix_valid = v;
    wif.sof       = s;
    if (v) model_accept(pix, s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(DW'($urandom), 1'b0, 1'($urandom_range(1)));
  endtask

  task automatic fill_src(input int kind);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (kind)
          0:       src[r][c] = DW'(r*8 + c);
          1:       src[r][c] = 8'hAA;
          default: src[r][c] = DW'($urandom);
        endcase
  endtask

  // sends src in raster order, stopping before (stop_r,stop_c) if reached
  task automatic send_frame(input int gap, input int stop_r, input int stop_c, input bit with_sof);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (r == stop_r && c == stop_c) return;
        while ($urandom_range(99) < gap) drive(DW'($urandom), 1'b0, 1'($urandom_range(1)));
        drive(src[r][c], 1'b1, with_sof && r == 0 && c == 0);
      end
  endtask

  always @(negedge clk) begin : mon
    win_t w;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      w = expq.pop_front();
      chk("win_valid", wif.win_valid, 1);
      chk("b", wif.b, w.b);
      chk("d", wif.d, w.d);
      chk("e", wif.e, w.e);
      chk("f", wif.f, w.f);
      chk("h", wif.h, w.h);
      chk("win_row", wif.win_row, w.row);
      chk("win_col", wif.win_col, w.col);
      chk("frame_done", wif.frame_done, w.done);
      if (n_win == 0) begin
        first_b = wif.b; first_d = wif.d; first_e = wif.e; first_f = wif.f; first_h = wif.h;
      end
      last_b = wif.b; last_d = wif.d; last_e = wif.e; last_f = wif.f; last_h = wif.h;
      last_row = int'(wif.win_row);
      last_col = int'(wif.win_col);
      n_win++;
      if (wif.frame_done) n_done++;
    end else begin
      chk("spurious_win", wif.win_valid, 0);
      chk("spurious_done", wif.frame_done, 0);
    end
  end

  initial begin
    rst_n         = 1'b0;
    wif.pix_in    = '0;
    wif.pix_valid = 1'b0;
    wif.sof       = 1'b0;
    #12;
    chk("rst_bdef", {wif.b, wif.d, wif.e, wif.f}, 0);
    chk("rst_h_ctl", {wif.h, wif.win_valid, wif.frame_done, wif.win_row, wif.win_col}, 0);
    rst_n = 1'b1;

    // gap-free ramp frame
    fill_src(0);
    n_win = 0; n_done = 0;
    send_frame(0, -1, -1, 1'b1);
    idle(3);
    chk("t1_nwin", n_win, 36);
    chk("t1_ndone", n_done, 1);
    chk("t1_first", {first_b, first_d, first_e, first_f, first_h}, {8'd1, 8'd8, 8'd9, 8'd10, 8'd17});
    chk("t1_last", {last_b, last_d, last_e, last_f, last_h}, {8'd46, 8'd53, 8'd54, 8'd55, 8'd62});
    chk("t1_last_rc", {last_row[7:0], last_col[7:0]}, {8'd5, 8'd5});

    // same frame with ~40% valid gaps
    n_win = 0; n_done = 0;
    send_frame(40, -1, -1, 1'b1);
    idle(3);
    chk("t2_nwin", n_win, 36);
    chk("t2_ndone", n_done, 1);
    chk("t2_last", {last_b, last_d, last_e, last_f, last_h}, {8'd46, 8'd53, 8'd54, 8'd55, 8'd62});

    // abort at (4,3) with sof, then a constant 0xAA frame
    n_win = 0; n_done = 0;
    send_frame(0, 4, 3, 1'b1);
    fill_src(1);
    send_frame(0, -1, -1, 1'b1);
    idle(3);
    chk("t3_nwin", n_win, 13 + 36);
    chk("t3_ndone", n_done, 1);
    chk("t3_last", {last_b, last_d, last_e, last_f, last_h}, {5{8'hAA}});

    // reset pulse after (5,5), then a frame without sof
    fill_src(2);
    send_frame(0, 5, 6, 1'b1);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    m_active = 1'b0;
    #2;
    chk("mid_rst_bdef", {wif.b, wif.d, wif.e, wif.f}, 0);
    chk("mid_rst_h_ctl", {wif.h, wif.win_valid, wif.frame_done, wif.win_row, wif.win_col}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_win = 0; n_done = 0;
    fill_src(0);
    send_frame(20, -1, -1, 1'b0);
    idle(2);
    chk("t4_nwin", n_win, 0);
    chk("t4_outs", {wif.b, wif.d, wif.e, wif.f, wif.h}, 0);

    // idle without sof, then two back-to-back random frames
    for (int i = 0; i < 20; i++) drive(DW'($urandom), 1'b1, 1'b0);
    chk("t5_idle_nwin", n_win, 0);
    fill_src(2);
    send_frame(0, -1, -1, 1'b1);
    fill_src(2);
    send_frame(0, -1, -1, 1'b1);
    idle(3);
    chk("t5_nwin", n_win, 72);
    chk("t5_ndone", n_done, 2);
    chk("pending", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/laplace_window_gen.md
Name: laplace_window_gen

Overview:
- Streaming front-end of the Laplace filter datapath.
- Accepts one raster-order pixel per valid cycle (row 0 col 0 first) and buffers the two previous rows.
- Emits the 5-point cross window (b,d,e,f,h) around each interior pixel to the combinational laplace9 kernels downstream.
- Output frame is (ROWS-2) x (COLS-2) windows, 510x510 for the standard 512x512 image.

Parameters:
- COLS, 512, pixels per input row (>=3).
- ROWS, 512, rows per input frame (>=3).
- DW, 8, pixel width in bits.
- CW, 9, width of coordinate outputs; must satisfy 2^CW >= max(COLS,ROWS).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_in  in  DW  input pixel.
- pix_valid  in  1  pix_in valid this cycle; no backpressure.
- sof  in  1  qualified by pix_valid; marks pixel (0,0) of a frame.
- b  out  DW  window north pixel.
- d  out  DW  window west pixel.
- e  out  DW  window centre pixel.
- f  out  DW  window east pixel.
- h  out  DW  window south pixel.
- win_valid  out  1  b..h, win_row and win_col valid this cycle (1-cycle pulse per window).
- win_row  out  CW  output row index, 0..ROWS-3.
- win_col  out  CW  output column index, 0..COLS-3.
- frame_done  out  1  1-cycle pulse coincident with the last window of a frame.

Behaviour:
- Reset (async, rst_n=0): b,d,e,f,h, win_valid, win_row, win_col and frame_done all 0. FSM goes to IDLE; counters cleared. Line-buffer contents are don't-care.
- Accept: a pixel is accepted on a rising edge with pix_valid=1. Cycles with pix_valid=0 change no state; outputs hold, except win_valid and frame_done, which drop to 0.
- Input counters: r (0..ROWS-1) and c (0..COLS-1) give the position of the accepted pixel. c wraps COLS-1 -> 0 and r increments on wrap.
- Storage: two line buffers of COLS x DW each, holding rows r-1 and r-2. Small shift registers hold the trailing row r-1 pixels at columns c-2 and c-1, and current row r at column c-1.
- FSM states:
  - IDLE: accepted pixels with sof=0 are dropped. sof=1 accepts the pixel as (0,0) and moves to FILL.
  - FILL: rows 0-1 and columns 0-1 of every row. Data is stored; no window is produced.
  - STREAM: entered on accepting the first pixel with r>=2 and c>=2, i.e. pixel (2,2). Stays in STREAM while r>=2. At row end (c=COLS-1) it remains in STREAM, and columns 0-1 of the next row produce no window.
  - Exit to IDLE on accepting (ROWS-1,COLS-1).
- Window mapping: accepting (r,c) with r>=2 and c>=2 produces, registered one cycle later:
  - b = P[r-2][c-1]
  - d = P[r-1][c-2]
  - e = P[r-1][c-1]
  - f = P[r-1][c]
  - h = P[r][c-1]
  - win_row = r-2, win_col = c-2, win_valid = 1.
- Latency: exactly 1 clock from the accepting edge to win_valid=1.
- frame_done: asserted together with the window for accepted pixel (ROWS-1,COLS-1). Exactly one window per interior position; (ROWS-2)*(COLS-2) windows per frame.
- sof mid-frame (FILL or STREAM, pix_valid=1): abort the current frame and treat the pixel as (0,0) of a new frame. No window is produced for it, no frame_done is issued, and the state goes to FILL. Stale buffer data is never used because the FILL rows are rewritten.
- sof on the cycle after frame completion (IDLE): normal start.
- Back-to-back frames: when frame N's last pixel is accepted and the next accepted pixel carries sof, frame N+1 starts with no idle cycles required.
- Reset mid-operation: immediate abort; the next frame requires sof.
- No arithmetic on pixel values; coordinates are unsigned and never exceed ROWS-3 / COLS-3.

Test Plan:
- ROWS=COLS=8, P[r][c]=r*8+c, pix_valid=1 continuously, sof on the first pixel -> first win_valid one cycle after accepting (2,2), with b=1, d=8, e=9, f=10, h=17, row=0, col=0. Totals: 36 windows, last window b=46, d=53, e=54, f=55, h=62, row=5, col=5, with frame_done=1 on that cycle only.
- Same image with random pix_valid gaps (about 40% low) -> window value and coordinate sequence identical to the gap-free run; win_valid never high during a gap.
- ROWS=COLS=8, sof re-asserted on accepted pixel (4,3) -> no frame_done for the aborted frame. New frame: first window appears only after the new (2,2), values taken from the new data (e.g. a constant 0xAA frame gives all outputs 0xAA), 36 windows.
- rst_n pulsed low for 1 cycle at (5,5), then a new frame without sof -> no windows until sof is seen. All outputs read 0 from assertion of rst_n onward.
- IDLE, 20 pixels with pix_valid=1 and sof=0 -> no windows, state stays IDLE. Two back-to-back 8x8 frames -> 72 windows, 2 frame_done pulses.
- 512x512 image loaded by $readmemb from the shared sw image text file, window outputs feeding laplace9_aprox_2 -> 260100 results. Filtered output must match bit-for-bit the software golden filtered image for the same approximation, written row-major.
